// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, state enum and code helpers for the data-memory access arbiter
//
// Purpose: access codes, exception codes, the address map and the arbiter
// state enum used by dm_access_arbiter and dm_subword_unit.
// Ports: none (package).
package dm_pkg;

  localparam logic [3:0] CODE_LW  = 4'b0000;
  localparam logic [3:0] CODE_SW  = 4'b0001;
  localparam logic [3:0] CODE_LH  = 4'b0010;
  localparam logic [3:0] CODE_LB  = 4'b0011;
  localparam logic [3:0] CODE_LHU = 4'b0100;
  localparam logic [3:0] CODE_LBU = 4'b0101;
  localparam logic [3:0] CODE_SH  = 4'b0110;
  localparam logic [3:0] CODE_SB  = 4'b0111;
  localparam logic [3:0] CODE_NO  = 4'b1000;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_LOAD  = 2'b10;
  localparam logic [1:0] EXC_STORE = 2'b11;

  localparam logic [31:0] DM_TOP    = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TMR1_BASE = 32'h0000_7F10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } dm_state_t;

  function automatic logic code_is_store(input logic [3:0] code);
    return (code == CODE_SW) || (code == CODE_SH) || (code == CODE_SB);
  endfunction

  function automatic logic code_is_word(input logic [3:0] code);
    return (code == CODE_LW) || (code == CODE_SW);
  endfunction

  function automatic logic code_is_half(input logic [3:0] code);
    return (code == CODE_LH) || (code == CODE_LHU) || (code == CODE_SH);
  endfunction

endpackage

// File: rtl/dm_subword_unit.sv
// rtl/dm_subword_unit.sv - combinational sub-word load extension and store lane merge
//
// Purpose: extracts the addressed byte/half from a memory word and sign- or
// zero-extends it for loads; builds the word to write back for sh/sb by
// replacing the addressed lane of the old word with the store data.
// Ports:
//   i_code   access code of the latched request
//   i_lane   byte address bits [1:0]
//   i_word   memory word (read data for loads, captured old word for merges)
//   i_wdata  right-aligned store data
//   o_load   extended load result (whole word for lw)
//   o_merged word to write (store data as-is for sw)
module dm_subword_unit
  import dm_pkg::*;
(
  input  logic [3:0]  i_code,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    o_load = i_word;
    case (i_code)
      CODE_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      CODE_LBU: o_load = {24'h000000, w_byte};
      CODE_LH:  o_load = {{16{w_half[15]}}, w_half};
      CODE_LHU: o_load = {16'h0000, w_half};
      default:  o_load = i_word;
    endcase

    o_merged = i_word;
    if (i_code == CODE_SB) begin
      o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
    end else if (i_code == CODE_SH) begin
      if (i_lane[1]) begin
        o_merged[31:16] = i_wdata[15:0];
      end else begin
        o_merged[15:0] = i_wdata[15:0];
      end
    end else begin
      o_merged = i_wdata;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - two-master arbiter and sequencer for data memory and timer windows
//
// Purpose: grants one of two requesters (m0 CPU, m1 debug/loader), decodes
// the address map, flags range/alignment faults, performs word and sub-word
// loads and stores (sh/sb as read-modify-write) and pulses the owner's done.
// Build option: FIXED_PRIO_EN - when defined, m0 always wins simultaneous
// requests and the round-robin pointer does not exist.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   mX_req/addr/wdata/code request handshake and fields per master
//   mX_done                one-cycle completion pulse to the owner
//   rdata, exc             load result and exception code, valid with done
//   mem_addr/wdata/we      word-indexed single-port data memory
//   mem_rdata              combinational memory read data
//   dev_sel/addr/we        timer window select, word within window, write strobe
//   dev_rdata              read data of the selected timer
module dm_access_arbiter
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_code,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_code,
  output logic        m1_done,
  output logic [31:0] rdata,
  output logic [1:0]  exc,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dev_sel,
  output logic        dev_addr,
  output logic        dev_we,
  input  logic [31:0] dev_rdata
);

  dm_state_t   r_state;
  dm_state_t   w_next;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_code;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic [1:0]  r_exc;

  logic        w_m0_ok;
  logic        w_m1_ok;
  logic        w_grant;
  logic        w_pick_m1;
  logic        w_in_dm;
  logic        w_in_t0;
  logic        w_in_t1;
  logic        w_in_tmr;
  logic        w_is_store;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_misalign;
  logic        w_fault;
  logic [31:0] w_rd_word;
  logic [31:0] w_sw_word;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // Codes above sb (including "no") are not accesses and are never granted.
  assign w_m0_ok = m0_req && (m0_code <= CODE_SB);
  assign w_m1_ok = m1_req && (m1_code <= CODE_SB);
  assign w_grant = w_m0_ok || w_m1_ok;

`ifdef FIXED_PRIO_EN
  assign w_pick_m1 = w_m1_ok && !w_m0_ok;
`else
  // r_rr = 1 gives m1 priority; it only moves when both masters contend.
  logic r_rr;
  assign w_pick_m1 = w_m1_ok && (!w_m0_ok || r_rr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_m0_ok && w_m1_ok) begin
      r_rr <= !w_pick_m1;
    end
  end
`endif

  // Address classification of the latched request.
  assign w_in_dm    = (r_addr <= DM_TOP);
  assign w_in_t0    = (r_addr[31:3] == TMR0_BASE[31:3]);
  assign w_in_t1    = (r_addr[31:3] == TMR1_BASE[31:3]);
  assign w_in_tmr   = w_in_t0 || w_in_t1;
  assign w_is_store = code_is_store(r_code);
  assign w_is_word  = code_is_word(r_code);
  assign w_is_half  = code_is_half(r_code);
  assign w_misalign = (w_is_word && (r_addr[1:0] != 2'b00)) || (w_is_half && r_addr[0]);
  // Timers are word-only registers, so any sub-word code to them faults.
  assign w_fault    = !(w_in_dm || w_in_tmr) || w_misalign || (!w_is_word && w_in_tmr);

  assign w_rd_word  = w_in_dm ? mem_rdata : dev_rdata;
  // One lane unit serves both: live read data in ACCESS, captured old word in MERGE.
  assign w_sw_word  = (r_state == ST_MERGE) ? r_word : w_rd_word;

  dm_subword_unit u_subword (
    .i_code   (r_code),
    .i_lane   (r_addr[1:0]),
    .i_word   (w_sw_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign mem_addr = r_addr[13:2];
  assign dev_addr = r_addr[2];
  assign rdata    = r_rdata;
  assign exc      = r_exc;
  assign m0_done  = (r_state == ST_RESP) && !r_owner && !reset;
  assign m1_done  = (r_state == ST_RESP) &&  r_owner && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    dev_we    = 1'b0;
    dev_sel   = 2'b00;
    mem_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!w_fault) begin
          dev_sel = w_in_t0 ? 2'b01 : (w_in_t1 ? 2'b10 : 2'b00);
          mem_we  = (r_code == CODE_SW) && w_in_dm;
          dev_we  = (r_code == CODE_SW) && w_in_tmr;
        end
        if (!w_fault && ((r_code == CODE_SH) || (r_code == CODE_SB))) begin
          w_next = ST_MERGE;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = w_merged;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // A reset in any state abandons the access without touching memory or timers.
    if (reset) begin
      mem_we  = 1'b0;
      dev_we  = 1'b0;
      dev_sel = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_code  <= CODE_NO;
      r_word  <= 32'h0;
      r_rdata <= 32'h0;
      r_exc   <= EXC_NONE;
    end else begin
      if ((r_state == ST_IDLE) && w_grant) begin
        r_owner <= w_pick_m1;
        r_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
        r_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
        r_code  <= w_pick_m1 ? m1_code  : m0_code;
      end
      if (r_state == ST_ACCESS) begin
        r_word <= mem_rdata;
        if (w_fault) begin
          r_rdata <= 32'h0;
          r_exc   <= w_is_store ? EXC_STORE : EXC_LOAD;
        end else begin
          r_rdata <= w_is_store ? 32'h0 : w_load;
          r_exc   <= EXC_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - scoreboard bench for dm_access_arbiter with a transaction-level reference model
module tb_dm_access_arbiter;

  localparam logic [3:0] C_LW = 4'd0, C_SW = 4'd1, C_LH = 4'd2, C_LB = 4'd3, C_LHU = 4'd4;
  localparam logic [3:0] C_LBU = 4'd5, C_SH = 4'd6, C_SB = 4'd7, C_NO = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0, m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m0_code = C_NO, m1_code = C_NO;
  logic        m0_done, m1_done;
  logic [31:0] rdata;
  logic [1:0]  exc;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [1:0]  dev_sel;
  logic        dev_addr;
  logic        dev_we;
  logic [31:0] dev_rdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { int cyc; bit m; logic [31:0] rdata; logic [1:0] exc; } done_t;
  typedef struct { int cyc; bit dev; logic [11:0] maddr; logic [1:0] sel; bit daddr; logic [31:0] data; } wr_t;
  done_t exp_done[$];
  wr_t   exp_wr[$];

  dm_access_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_code(m0_code), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_code(m1_code), .m1_done(m1_done),
    .rdata(rdata), .exc(exc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_we(dev_we), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return i * 32'h9E37_79B1 + 32'h0000_1357;
  endfunction

  function automatic logic [31:0] init_tmr(input int i);
    return 32'hA500_0000 + i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Environment: word memory and two 2-word timers that the DUT drives.
  logic [31:0] env_mem [4096];
  logic [31:0] env_tmr [4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) env_mem[i] <= init_word(i);
      for (int i = 0; i < 4; i++) env_tmr[i] <= init_tmr(i);
    end else begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      if (dev_we && dev_sel == 2'b01) env_tmr[{1'b0, dev_addr}] <= mem_wdata;
      if (dev_we && dev_sel == 2'b10) env_tmr[{1'b1, dev_addr}] <= mem_wdata;
    end
  end
  assign mem_rdata = env_mem[mem_addr];
  assign dev_rdata = (dev_sel == 2'b01) ? env_tmr[{1'b0, dev_addr}] :
                     (dev_sel == 2'b10) ? env_tmr[{1'b1, dev_addr}] : 32'hBADC_0DE0;

  // Reference model: one transaction at a time, results from the address map rules.
  logic [31:0] sh_mem [4096];
  logic [31:0] sh_tmr [4];
  int free_cyc = 0;
  bit prio_m1 = 1'b0;

  task automatic model_access(input bit who, input logic [3:0] code, input logic [31:0] a, input logic [31:0] wd);
    bit dm, t0, t1, word, half, store, fault;
    int lane, ti, sft;
    logic [31:0] w, b, h, res, nw;
    done_t d;
    wr_t wr;
    dm    = (a <= 32'h2FFF);
    t0    = (a >= 32'h7F00) && (a <= 32'h7F07);
    t1    = (a >= 32'h7F10) && (a <= 32'h7F17);
    word  = (code == C_LW) || (code == C_SW);
    half  = (code == C_LH) || (code == C_LHU) || (code == C_SH);
    store = (code == C_SW) || (code == C_SH) || (code == C_SB);
    fault = !(dm || t0 || t1) || (word && (a % 4 != 0)) || (half && (a % 2 != 0)) || (!word && (t0 || t1));
    lane  = int'(a % 4);
    ti    = (t1 ? 2 : 0) + int'((a / 4) % 2);
    w     = dm ? sh_mem[(a / 4) % 4096] : sh_tmr[ti];
    b     = (w >> (8 * lane)) & 32'hFF;
    h     = (w >> (16 * (lane / 2))) & 32'hFFFF;
    res   = 32'h0;
    d.cyc = cyc + 2;
    d.m   = who;
    d.exc = fault ? (store ? 2'b11 : 2'b10) : 2'b00;
    wr.dev = !dm; wr.maddr = 12'((a / 4) % 4096); wr.sel = t0 ? 2'b01 : 2'b10;
    wr.daddr = ((a / 4) % 2) == 1; wr.cyc = cyc + 1; wr.data = wd;
    if (!fault) begin
      case (code)
        C_LW:  res = w;
        C_LB:  res = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        C_LBU: res = b;
        C_LH:  res = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
        C_LHU: res = h;
        C_SW: begin
          if (dm) sh_mem[(a / 4) % 4096] = wd; else sh_tmr[ti] = wd;
          exp_wr.push_back(wr);
        end
        C_SH, C_SB: begin
          sft = (code == C_SH) ? 16 * (lane / 2) : 8 * lane;
          nw = (code == C_SH) ? ((w & ~(32'hFFFF << sft)) | ((wd & 32'hFFFF) << sft))
                              : ((w & ~(32'hFF << sft)) | ((wd & 32'hFF) << sft));
          sh_mem[(a / 4) % 4096] = nw;
          wr.cyc = cyc + 2; wr.data = nw;
          exp_wr.push_back(wr);
          d.cyc = cyc + 3;
        end
        default: res = 32'h0;
      endcase
    end
    d.rdata = res;
    exp_done.push_back(d);
    free_cyc = d.cyc + 1;
  endtask

  always @(negedge clk) begin
    bit ok0, ok1, who;
    if (reset) begin
      for (int i = 0; i < 4096; i++) sh_mem[i] = init_word(i);
      for (int i = 0; i < 4; i++) sh_tmr[i] = init_tmr(i);
      exp_done.delete();
      exp_wr.delete();
      free_cyc = cyc + 1;
      prio_m1 = 1'b0;
    end else if (cyc >= free_cyc) begin
      ok0 = m0_req && (m0_code != C_NO);
      ok1 = m1_req && (m1_code != C_NO);
      if (ok0 || ok1) begin
`ifdef FIXED_PRIO_EN
        who = !ok0;
`else
        if (ok0 && ok1) begin
          who = prio_m1;
          prio_m1 = !who;
        end else begin
          who = ok1;
        end
`endif
        if (who) model_access(1'b1, m1_code, m1_addr, m1_wdata);
        else     model_access(1'b0, m0_code, m0_addr, m0_wdata);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a done or a write strobe.
  always @(negedge clk) begin
    done_t d;
    wr_t w;
    while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL done_missing: m%0d done due at cycle %0d, not observed by cycle %0d", exp_done[0].m, exp_done[0].cyc, cyc);
      void'(exp_done.pop_front());
    end
    while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL write_missing: write due at cycle %0d, not observed by cycle %0d", exp_wr[0].cyc, cyc);
      void'(exp_wr.pop_front());
    end
    if (m0_done || m1_done) begin
      check("one_done", {31'h0, m0_done && m1_done}, 32'h0);
      if (exp_done.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: m0_done=%0d m1_done=%0d, required none", m0_done, m1_done);
      end else begin
        d = exp_done.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_owner", {31'h0, m1_done}, {31'h0, d.m});
        check("rdata", rdata, d.rdata);
        check("exc", {30'h0, exc}, {30'h0, d.exc});
      end
    end
    if (mem_we || dev_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: mem_we=%0d dev_we=%0d, required none", mem_we, dev_we);
      end else begin
        w = exp_wr.pop_front();
        check("write_cycle", cyc, w.cyc);
        check("write_kind", {30'h0, mem_we, dev_we}, w.dev ? 32'h1 : 32'h2);
        check("write_data", mem_wdata, w.data);
        if (w.dev) begin
          check("dev_sel", {30'h0, dev_sel}, {30'h0, w.sel});
          check("dev_addr", {31'h0, dev_addr}, {31'h0, w.daddr});
        end else begin
          check("mem_addr", {20'h0, mem_addr}, {20'h0, w.maddr});
        end
      end
    end
  end

  task automatic drive(input int m, input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = r; m0_code = c; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = r; m1_code = c; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input int m, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    int waited;
    bit seen;
    waited = 0;
    seen = 1'b0;
    drive(m, 1'b1, c, a, d);
    if (c == C_NO) begin
      repeat (3) @(posedge clk);
      #1;
      drive(m, 1'b0, c, a, d);
    end else begin
      while (!seen && waited < 40) begin
        @(negedge clk);
        waited++;
        seen = (m == 0) ? m0_done : m1_done;
      end
      check("done_within_bound", {31'h0, seen}, 32'h1);
      @(posedge clk);
      #1;
      drive(m, 1'b0, c, a, d);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 63));
      1:       return 32'h2FF0 + 32'($urandom_range(0, 31));
      2:       return 32'h7F00 + 32'($urandom_range(0, 23));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int m, input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 8));
      issue(m, c, rand_addr(), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m0_done"}, {31'h0, m0_done}, 32'h0);
    check({tag, "_m1_done"}, {31'h0, m1_done}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_exc"}, {30'h0, exc}, 32'h0);
    check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, "_dev_we"}, {31'h0, dev_we}, 32'h0);
    check({tag, "_dev_sel"}, {30'h0, dev_sel}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
    @(posedge clk);
    #1;

    // Directed cases from the address map and lane rules.
    issue(0, C_SW, 32'h10, 32'hDEAD_BEEF);
    issue(0, C_LW, 32'h10, 32'h0);
    issue(0, C_SW, 32'h20, 32'h1122_3344);
    issue(1, C_SB, 32'h21, 32'h0000_00AA);
    issue(1, C_LB, 32'h21, 32'h0);
    issue(1, C_LBU, 32'h21, 32'h0);
    issue(1, C_LH, 32'h22, 32'h0);
    issue(0, C_SH, 32'h22, 32'h0000_8001);
    issue(0, C_LHU, 32'h22, 32'h0);
    issue(0, C_LW, 32'h3000, 32'h0);
    issue(0, C_SW, 32'h2, 32'h1);
    issue(0, C_LH, 32'h7F00, 32'h0);
    issue(0, C_SW, 32'h7F14, 32'h5);
    issue(0, C_LW, 32'h7F14, 32'h0);
    issue(1, C_LW, 32'h2FFC, 32'h0);

    // Both masters held busy: grant order is decided by the model's arbitration rule.
    fork
      for (int k = 0; k < 4; k++) issue(0, C_LW, 32'h10, 32'h0);
      for (int k = 0; k < 4; k++) issue(1, C_LW, 32'h20, 32'h0);
    join

    fork
      rand_ops(0, 60);
      rand_ops(1, 60);
    join

    // Reset while an sh sits in its merge cycle.
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, C_SH, 32'h22, 32'h0000_BEEF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, C_SH, 32'h22, 32'h0000_BEEF);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("merge_reset_mem_we", {31'h0, mem_we}, 32'h0);
    check("merge_reset_m0_done", {31'h0, m0_done}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_merge_reset");
    @(posedge clk);
    #1;

    fork
      for (int k = 0; k < 3; k++) issue(0, C_LW, 32'h24, 32'h0);
      for (int k = 0; k < 3; k++) issue(1, C_LBU, 32'h27, 32'h0);
    join

    repeat (10) @(posedge clk);
    check("done_queue_drained", 32'(exp_done.size()), 32'h0);
    check("write_queue_drained", 32'(exp_wr.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Sequences and shares the single-port data memory and the two timer register windows between two requesters: m0 is the CPU data port, m1 is the debug/loader port.
- Each access is a request/done handshake.
- The block decodes the address map and checks alignment and range, flagging exceptions.
- Sub-word loads are extracted and sign/zero-extended here; sub-word stores run as read-modify-write against the word-only memory.

Parameters:
- DM_TOP, 32'h00002FFF, last byte address of the data memory.
- TMR0_BASE, 32'h00007F00, timer 0 window base (8 bytes).
- TMR1_BASE, 32'h00007F10, timer 1 window base (8 bytes).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- m0_req, m1_req  input  1 each  request; held with fields stable until matching done
- m0_addr, m1_addr  input  32 each  byte address
- m0_wdata, m1_wdata  input  32 each  store data, right-aligned for sh/sb
- m0_code, m1_code  input  4 each  access code: lw 0000, sw 0001, lh 0010, lb 0011, lhu 0100, lbu 0101, sh 0110, sb 0111, no 1000
- m0_done, m1_done  output  1 each  one-cycle completion pulse
- rdata  output  32  extended load result, valid with done
- exc  output  2  00 none, 10 load fault, 11 store fault; valid with done
- mem_addr  output  12  word index (addr[13:2])
- mem_wdata  output  32  word to write
- mem_we  output  1  memory write strobe
- mem_rdata  input  32  combinational memory read
- dev_sel  output  2  01 timer0, 10 timer1, 00 none
- dev_addr  output  1  word within window (addr[2])
- dev_we  output  1  device write strobe
- dev_rdata  input  32  selected device read data

Behaviour:
- Reset values: state IDLE, rr pointer = m0, done 0, rdata 0, exc 0, mem_we 0, dev_we 0, dev_sel 00. Strobes are gated by !reset.
- A reset mid-transaction abandons the access; no write is issued.
- IDLE: grant to a requester whose req=1 and code != no.
  - If both request, the rr pointer wins; the pointer then moves to the other master.
  - Address, data, code and owner are latched in this cycle (N).
- ACCESS (N+1): classify the latched address.
  - Range fault: address outside 0..DM_TOP and outside both timer windows.
  - Alignment fault: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0.
  - Any sub-word code to a timer window is a fault.
  - Fault: no strobes; exc=11 for stores, 10 for loads; go to RESP.
  - Word load: capture mem_rdata or dev_rdata; go to RESP.
  - sw: mem_we=1 (DM) or dev_we=1 (timer) with the latched data; go to RESP.
  - sh/sb: capture mem_rdata; go to MERGE.
- MERGE (N+2, sh/sb only): mem_we=1.
  - mem_wdata is the captured word with the byte lane (addr[1:0]) or half lane (addr[1]) replaced by the store data.
  - Then go to RESP.
- RESP: owner's done=1 for one cycle, with rdata/exc; return to IDLE.
- A requester holding req after done starts a new transaction in the next IDLE cycle.
- Latency:
  - All loads, sw and all faults: done at N+2.
  - sh/sb: done at N+3.
  - Max request-to-grant wait is one full transaction.
- Load extension: lb/lh sign-extend, lbu/lhu zero-extend, from the selected byte/half lane. Stores return rdata=0.
- A request with code=no is never granted. Exactly one done is asserted at a time.

Optional Feature:
- FIXED_PRIO_EN.
  - Defined: m0 always wins simultaneous requests; the rr pointer is removed.
  - Undefined: round-robin as above.

Decomposition:
- Shared package dm_pkg:
  - access code constants
  - exc codes
  - DM_TOP and timer base constants
  - state enum (IDLE, ACCESS, MERGE, RESP)
- One sub-module, dm_subword_unit: combinational load extraction/extension and store lane merge.

Test Plan:
- m0 sw 0x00000010 data 0xDEADBEEF, then lw 0x10: mem_we at N+1, mem_addr 4; lw done at N+2 with rdata 0xDEADBEEF, exc 00.
- Word at 0x20 = 0x11223344, m1 sb 0xAA to 0x21: read at N+1, write 0x1122AA44 at N+2, done N+3; then lb 0x21 returns 0xFFFFFFAA and lbu 0x21 returns 0x000000AA.
- m0 lw 0x3000 gives exc 10; m0 sw 0x0002 gives exc 11; m0 lh 0x7F00 gives exc 10; in all cases no mem_we/dev_we.
- m0 sw 0x7F14 data 5: dev_sel 10, dev_addr 1, dev_we 1, done N+2.
- Both req held continuously: grants alternate m0, m1, m0, ...; with FIXED_PRIO_EN, m0 is granted repeatedly.
- Reset asserted in MERGE cycle of an sh: no mem_we, no done; outputs return to reset values next cycle.
